vga_timing: RTL and testbench

//  Pixel-rate VGA raster generator for the 800x480 display. Free-running h/v counters drive the

---
 rtl/vga_timing.sv | 144 ++++++++++++++
 tb/tb_vga_timing.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : Pixel-rate VGA raster generator. Free-running h/v counters feed
//                the frame buffer; returned pixel bits become registered,
//                position-aligned hsync/vsync/de/RGB444.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int          H_ACTIVE = 800,
    parameter int          H_FP     = 40,
    parameter int          H_SYNC   = 128,
    parameter int          H_BP     = 88,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 13,
    parameter int          V_SYNC   = 3,
    parameter int          V_BP     = 29,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int          PIPE_LAT = 1,
    parameter logic [11:0] FG       = 12'hFFF,
    parameter logic [11:0] BG       = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_in,
    output logic [10:0] vga_h,
    output logic [10:0] vga_v,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start,
    output logic        line_start
);

    localparam int          c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] c_h_last   = 11'(c_h_total - 1);
    localparam logic [10:0] c_v_last   = 11'(c_v_total - 1);
    localparam logic [10:0] c_h_act    = 11'(H_ACTIVE);
    localparam logic [10:0] c_v_act    = 11'(V_ACTIVE);
    localparam logic [10:0] c_hs_start = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_hs_end   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_vs_start = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_vs_end   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_h;
    logic [10:0] r_v;
    logic        w_act;
    logic        w_hs;
    logic        w_vs;
    logic        w_line0;
    logic        w_frame0;
    logic [4:0]  w_raw;
    logic [4:0]  w_dly;
    logic [11:0] w_rgb;

    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [11:0] r_rgb;
    logic        r_frame_start;
    logic        r_line_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == c_h_last) begin
            r_h <= '0;
            r_v <= (r_v == c_v_last) ? 11'd0 : r_v + 11'd1;
        end else begin
            r_h <= r_h + 11'd1;
        end
    end

    assign w_act    = (r_h < c_h_act) && (r_v < c_v_act);
    assign w_hs     = (r_h >= c_hs_start) && (r_h < c_hs_end);
    assign w_vs     = (r_v >= c_vs_start) && (r_v < c_vs_end);
    assign w_line0  = (r_h == 11'd0);
    assign w_frame0 = (r_h == 11'd0) && (r_v == 11'd0);
    assign w_raw    = {w_frame0, w_line0, w_vs, w_hs, w_act};

    // Delay the decode by the frame buffer read latency so it meets pixel_in.
    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign w_dly = w_raw;
        end else begin : g_pipe
            logic [4:0] r_pipe [PIPE_LAT];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_dly = r_pipe[PIPE_LAT-1];
        end
    endgenerate

    // Blanking is forced black regardless of what the frame buffer returns.
    assign w_rgb = w_dly[0] ? (pixel_in ? FG : BG) : 12'h000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_de          <= 1'b0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_rgb         <= 12'h000;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_de          <= w_dly[0];
            r_hsync       <= w_dly[1] ? HS_POL : ~HS_POL;
            r_vsync       <= w_dly[2] ? VS_POL : ~VS_POL;
            r_rgb         <= w_rgb;
            r_line_start  <= w_dly[3];
            r_frame_start <= w_dly[4];
        end
    end

    assign vga_h       = r_h;
    assign vga_v       = r_v;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign frame_start = r_frame_start;
    assign line_start  = r_line_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing
//  Description : Self-checking bench for vga_timing on a reduced raster.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    localparam int          HA  = 40;
    localparam int          HFP = 4;
    localparam int          HSW = 8;
    localparam int          HBP = 6;
    localparam int          VA  = 20;
    localparam int          VFP = 3;
    localparam int          VSW = 2;
    localparam int          VBP = 4;
    localparam bit          HSP = 1'b0;
    localparam bit          VSP = 1'b1;
    localparam logic [11:0] FGC = 12'hA5C;
    localparam logic [11:0] BGC = 12'h123;
    localparam int          HT  = HA + HFP + HSW + HBP;
    localparam int          VT  = VA + VFP + VSW + VBP;
    localparam int          FRAME = HT * VT;
    localparam logic [16:0] RST_VEC = {1'b0, 1'b0, 1'b0, ~HSP, ~VSP, 12'h000};

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_in;
    logic [10:0] vga_h;
    logic [10:0] vga_v;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        frame_start;
    logic        line_start;

    int          n_cmp = 0;
    int          n_err = 0;
    int          mh;
    int          mv;
    int          mode;
    logic        prev_pix;
    logic [16:0] exp_q [$];

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .PIPE_LAT(1), .FG(FGC), .BG(BGC)
    ) u_dut (
        .clk(clk), .reset(reset), .pixel_in(pixel_in),
        .vga_h(vga_h), .vga_v(vga_v), .hsync(hsync), .vsync(vsync), .de(de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .line_start(line_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (model h=%0d v=%0d)", tag, got, exp, mh, mv);
        end
    endtask

    function automatic logic [16:0] obs_vec();
        return {frame_start, line_start, de, hsync, vsync, vga_r, vga_g, vga_b};
    endfunction

    // Mode 0: busy pattern that also drives 1 throughout blanking; mode 1: one lit pixel.
    function automatic logic pix_of(input int h, input int v);
        if (mode == 0) return (((h + 2 * v) % 7) == 0) || (h >= HA) || (v >= VA);
        return (h == 30) && (v == 10);
    endfunction

    function automatic logic [16:0] exp_vec(input int h, input int v, input logic p);
        logic        act;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        act = (h < HA) && (v < VA);
        hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs  = (v >= VA + VFP) && (v < VA + VFP + VSW);
        rgb = act ? (p ? FGC : BGC) : 12'h000;
        return {(h == 0) && (v == 0), h == 0, act, hs ? HSP : ~HSP, vs ? VSP : ~VSP, rgb};
    endfunction

    // Called at a falling edge; checks the current cycle, then feeds pixel_in with the
    // frame buffer's answer for the previous raster position.
    task automatic step();
        logic pcur;
        check("vga_h", 32'(vga_h), 32'(mh));
        check("vga_v", 32'(vga_v), 32'(mv));
        pcur = pix_of(mh, mv);
        exp_q.push_back(exp_vec(mh, mv, pcur));
        check("outputs", 32'(obs_vec()), 32'(exp_q.pop_front()));
        pixel_in = prev_pix;
        prev_pix = pcur;
        mh++;
        if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_h"}, 32'(vga_h), 32'd0);
        check({tag, "_v"}, 32'(vga_v), 32'd0);
        check({tag, "_out"}, 32'(obs_vec()), 32'(RST_VEC));
    endtask

    // Must be called at a falling edge while reset is asserted.
    task automatic release_reset();
        reset    = 1'b0;
        mh       = 0;
        mv       = 0;
        prev_pix = 1'b0;
        pixel_in = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST_VEC);
        exp_q.push_back(RST_VEC);
        #1;
        step();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            step();
        end
    endtask

    initial begin
        int guard;
        reset    = 1'b1;
        pixel_in = 1'b0;
        mode     = 0;
        mh       = 0;
        mv       = 0;
        prev_pix = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset_init");
        release_reset();

        run(FRAME + 100);
        mode = 1;
        run(FRAME + 60);

        guard = 0;
        while (!((mh == 25) && (mv == 12)) && (guard < 2 * FRAME)) begin
            @(negedge clk);
            step();
            guard++;
        end
        check("reach_pos", 32'(guard < 2 * FRAME), 32'd1);

        @(posedge clk);
        #2;
        check("pre_reset_h", 32'(vga_h), 32'd25);
        check("pre_reset_de", 32'(de), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        #1;
        check_reset_state("reset_held");
        @(negedge clk);
        mode = 0;
        release_reset();
        run(FRAME + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
